// File: rtl/anode_scanner.sv
// anode_scanner: scans a 4-digit common-anode display with a blanking gap at the start of each slot.
// Optional macro DIGIT_DIM_EN adds a bright input and per-slot 4-bit PWM dimming.
module anode_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] digit_en,
`ifdef DIGIT_DIM_EN
    input  logic [3:0] bright,
`endif
    output logic [3:0] anode,
    output logic [1:0] digit_idx,
    output logic       slot_start,
    output logic       frame_done
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLK = CW'(BLANK_CYCLES);

    if (REFRESH_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_param_check
        $error("anode_scanner: need REFRESH_DIV >= 2 and 0 <= BLANK_CYCLES < REFRESH_DIV");
    end

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    anode_q, anode_d;
    logic          slot_start_q, slot_start_d;
    logic          frame_done_q, frame_done_d;
    logic          lit;
`ifdef DIGIT_DIM_EN
    logic [3:0]    bright_q, bright_d;
    logic [3:0]    pwm_q, pwm_d;
`endif

    // Outputs are derived from the next state so they line up with it once registered.
    always_comb begin
        state_d      = IDLE;
        cnt_d        = '0;
        idx_d        = 2'd0;
        anode_d      = 4'hF;
        slot_start_d = 1'b0;
        frame_done_d = 1'b0;
        lit          = 1'b1;
`ifdef DIGIT_DIM_EN
        bright_d     = bright_q;
        pwm_d        = 4'd0;
`endif
        if (en) begin
            if (state_q != IDLE) begin
                cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                idx_d = (cnt_q == LAST) ? idx_q + 2'd1 : idx_q;
            end
            state_d      = (cnt_d < BLK) ? BLANK : DRIVE;
            slot_start_d = (cnt_d == '0);
            frame_done_d = (idx_d == 2'd3) && (cnt_d == LAST);
`ifdef DIGIT_DIM_EN
            bright_d = slot_start_d ? bright : bright_q;
            pwm_d    = (state_d == DRIVE && cnt_d != BLK) ? pwm_q + 4'd1 : 4'd0;
            lit      = (pwm_d < bright_d) || (bright_d == 4'hF);
`endif
            anode_d = (state_d == DRIVE && digit_en[idx_d] && lit) ? ~(4'b0001 << idx_d) : 4'hF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            anode_q      <= 4'hF;
            slot_start_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            anode_q      <= anode_d;
            slot_start_q <= slot_start_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef DIGIT_DIM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_q <= 4'd0;
            pwm_q    <= 4'd0;
        end else begin
            bright_q <= bright_d;
            pwm_q    <= pwm_d;
        end
    end
`endif

    assign anode      = anode_q;
    assign digit_idx  = idx_q;
    assign slot_start = slot_start_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_anode_scanner.sv
// tb_anode_scanner: directed bench for anode_scanner with REFRESH_DIV=8, BLANK_CYCLES=2.
// With DIGIT_DIM_EN defined, a second instance (40/8) exercises the PWM brightness path.
module tb_anode_scanner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] digit_en = 4'hF;
    logic [3:0] anode;
    logic [1:0] digit_idx;
    logic       slot_start, frame_done;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    anode_scanner #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .digit_en(digit_en),
`ifdef DIGIT_DIM_EN
        .bright(4'hF),
`endif
        .anode(anode), .digit_idx(digit_idx), .slot_start(slot_start), .frame_done(frame_done)
    );

`ifdef DIGIT_DIM_EN
    logic       en2 = 1'b0;
    logic [3:0] bright2 = 4'd0;
    logic [3:0] anode2;
    logic [1:0] idx2;
    logic       ss2, fd2;
    int         lit;
    anode_scanner #(.REFRESH_DIV(40), .BLANK_CYCLES(8)) dut_dim (
        .clk(clk), .rst_n(rst_n), .en(en2), .digit_en(4'hF), .bright(bright2),
        .anode(anode2), .digit_idx(idx2), .slot_start(ss2), .frame_done(fd2)
    );
`endif

    typedef struct {
        logic [3:0] den;
        logic [3:0] drive;
        logic [1:0] idx;
    } slot_vec_t;
    slot_vec_t vec [9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] a, input logic [1:0] i,
                             input logic s, input logic f);
        check({tag, ".anode"}, {4'h0, anode}, {4'h0, a});
        check({tag, ".idx"}, {6'h0, digit_idx}, {6'h0, i});
        check({tag, ".slot_start"}, {7'h0, slot_start}, {7'h0, s});
        check({tag, ".frame_done"}, {7'h0, frame_done}, {7'h0, f});
    endtask

    initial begin
        // {digit_en for the slot, anode expected in DRIVE, digit index}
        vec[0] = '{4'hF, 4'hE, 2'd0};
        vec[1] = '{4'hF, 4'hD, 2'd1};
        vec[2] = '{4'hF, 4'hB, 2'd2};
        vec[3] = '{4'hF, 4'h7, 2'd3};
        vec[4] = '{4'hF, 4'hE, 2'd0};
        vec[5] = '{4'hB, 4'hD, 2'd1};
        vec[6] = '{4'hB, 4'hF, 2'd2};
        vec[7] = '{4'hB, 4'h7, 2'd3};
        vec[8] = '{4'hB, 4'hE, 2'd0};

        #12;
        check_out("reset", 4'hF, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        for (int v = 0; v < 9; v++) begin
            digit_en = vec[v].den;
            for (int c = 0; c < 8; c++) begin
                @(posedge clk); #1;
                check_out($sformatf("slot%0d_c%0d", v, c), (c < 2) ? 4'hF : vec[v].drive,
                          vec[v].idx, c == 0, vec[v].idx == 2'd3 && c == 7);
            end
        end

        // drop en on the third DRIVE cycle of idx2, then restart
        digit_en = 4'hF;
        repeat (8) @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
        end
        check_out("en_drop_pre", 4'hB, 2'd2, 1'b0, 1'b0);
        en = 1'b0;
        @(posedge clk); #1;
        check_out("en_drop", 4'hF, 2'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_out("idle_hold", 4'hF, 2'd0, 1'b0, 1'b0);
        en = 1'b1;
        @(posedge clk); #1;
        check_out("reen_c0", 4'hF, 2'd0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check_out("reen_c1", 4'hF, 2'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_out("reen_c2", 4'hE, 2'd0, 1'b0, 1'b0);

        // asynchronous reset between edges while driving
        @(posedge clk); #1;
        check_out("pre_rst", 4'hE, 2'd0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check_out("rst_async", 4'hF, 2'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_out("rst_hold", 4'hF, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_out("rst_release", 4'hF, 2'd0, 1'b1, 1'b0);

`ifdef DIGIT_DIM_EN
        @(negedge clk);
        en2 = 1'b1;
        for (int s = 0; s < 3; s++) begin
            bright2 = (s == 0) ? 4'd4 : ((s == 1) ? 4'd15 : 4'd0);
            lit = 0;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
                if (anode2 != 4'hF) lit++;
                if (c == 0) check($sformatf("dim%0d_slot_start", s), {7'h0, ss2}, 8'h01);
                if (c == 8 && s == 0) check("dim0_first_drive", {4'h0, anode2}, 8'h0E);
            end
            check($sformatf("dim%0d_lit_cycles", s), 8'(lit), (s == 0) ? 8'd8 : ((s == 1) ? 8'd32 : 8'd0));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
